// File: rtl/lfm_chirp_seq.sv
// Linear-FM chirp sequencer: streams swept phase-increment words to a DDS,
// with optional idle gaps between chirps and continuous repetition until stop.
`timescale 1ns/1ps
module lfm_chirp_seq #(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] cfg_start_inc,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic               cfg_continuous,
    output logic               phase_valid,
    input  logic               phase_ready,
    output logic [PHASE_W-1:0] phase_data,
    output logic               chirp_last,
    output logic               busy,
    output logic [CNT_W-1:0]   chirp_count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PHASE_W-1:0] start_inc_q, start_inc_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic               cont_q, cont_d;
    logic               stop_seen_q, stop_seen_d;

    logic               accept;
    logic               continuing;
    logic [CNT_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   len_m1;

    // Handshake: a word transfers on every cycle with phase_valid && phase_ready.
    // While phase_valid is high and phase_ready low, phase_data/chirp_last hold.
    assign accept     = valid_q && phase_ready;
    assign continuing = cont_q && !stop_seen_q && !stop;
    assign idx_nxt    = idx_q + CNT_W'(1);
    assign len_m1     = len_q - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        valid_d     = valid_q;
        last_d      = last_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        count_d     = count_q;
        start_inc_d = start_inc_q;
        step_d      = step_q;
        len_d       = len_q;
        gap_d       = gap_q;
        cont_d      = cont_q;
        stop_seen_d = stop_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    start_inc_d = cfg_start_inc;
                    step_d      = cfg_step;
                    len_d       = cfg_len;
                    gap_d       = cfg_gap;
                    cont_d      = cfg_continuous;
                    stop_seen_d = stop;
                    state_d     = ST_SWEEP;
                    valid_d     = 1'b1;
                    acc_d       = cfg_start_inc;
                    idx_d       = '0;
                    last_d      = (cfg_len == CNT_W'(1));
                end
            end

            ST_SWEEP: begin
                if (stop) begin
                    stop_seen_d = 1'b1;
                end
                if (accept) begin
                    if (last_q) begin
                        count_d = count_q + CNT_W'(1);
                        if (!continuing) begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                            valid_d   = 1'b0;
                            last_d    = 1'b0;
                        end else begin
                            // Zero gap: next chirp's first word follows with no bubble.
                            acc_d  = start_inc_q;
                            idx_d  = '0;
                            last_d = (len_q == CNT_W'(1));
                        end
                    end else begin
                        acc_d  = acc_q + step_q;
                        idx_d  = idx_nxt;
                        last_d = (idx_nxt == len_m1);
                    end
                end
            end

            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == CNT_W'(1)) begin
                    state_d = ST_SWEEP;
                    valid_d = 1'b1;
                    acc_d   = start_inc_q;
                    idx_d   = '0;
                    last_d  = (len_q == CNT_W'(1));
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            count_q     <= '0;
            start_inc_q <= '0;
            step_q      <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            cont_q      <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            count_q     <= count_d;
            start_inc_q <= start_inc_d;
            step_q      <= step_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            cont_q      <= cont_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    assign phase_valid = valid_q;
    assign phase_data  = acc_q;
    assign chirp_last  = last_q;
    assign busy        = (state_q != ST_IDLE);
    assign chirp_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/lfm_chirp_seq.md
LFM_CHIRP_SEQ -- requirements
Module: lfm_chirp_seq

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, width of phase increment words sent to the DDS phase input.
REQ-002 SHALL have parameter CNT_W, default 16, width of length, gap and chirp counters.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a chirp sequence.
REQ-006 SHALL have port stop  input  1  one-cycle request to end continuous operation after the current chirp.
REQ-007 SHALL have port cfg_start_inc  input  PHASE_W  first phase increment of each chirp.
REQ-008 SHALL have port cfg_step  input  PHASE_W  per-sample increment delta (chirp rate), two's complement.
REQ-009 SHALL have port cfg_len  input  CNT_W  samples per chirp.
REQ-010 SHALL have port cfg_gap  input  CNT_W  idle cycles between chirps.
REQ-011 SHALL have port cfg_continuous  input  1  repeat chirps until stop.
REQ-012 SHALL have port phase_valid  output  1  phase_data valid toward the DDS.
REQ-013 SHALL have port phase_ready  input  1  DDS accepts phase_data this cycle.
REQ-014 SHALL have port phase_data  output  PHASE_W  phase increment word.
REQ-015 SHALL have port chirp_last  output  1  marks final sample of a chirp; qualified by phase_valid.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port chirp_count  output  CNT_W  number of completed chirps since reset; wraps.

Function
REQ-018 SHALL implement FSM states IDLE, SWEEP, GAP.
REQ-019 In IDLE, start=1 with cfg_len!=0 SHALL latch all cfg_* inputs and enter SWEEP next cycle. phase_valid=1 and phase_data=cfg_start_inc SHALL appear in that cycle.
REQ-020 start with cfg_len==0 SHALL be ignored. start outside IDLE SHALL be ignored. cfg_* SHALL be sampled only at an accepted start.
REQ-021 In SWEEP, phase_valid SHALL be 1. Sample k (k=0..len-1) SHALL be start_inc + k*step mod 2^PHASE_W, computed by accumulation with no multiplier.
REQ-022 The sample index SHALL advance only on phase_valid&&phase_ready. phase_data and chirp_last SHALL be held stable while phase_ready=0.
REQ-023 chirp_last SHALL be 1 exactly on sample k=len-1. chirp_count SHALL increment when that sample is accepted.
REQ-024 After the last sample is accepted:
  - gap>0: enter GAP with phase_valid=0 for exactly gap cycles.
  - gap==0 and continuing: the next cycle SHALL present sample 0 of a new chirp with no bubble.
REQ-025 "Continuing" SHALL mean continuous latched=1 and no stop received since start. Otherwise the FSM SHALL return to IDLE instead of GAP/SWEEP. Stop SHALL also skip the gap.
REQ-026 stop SHALL never drop phase_valid mid-chirp; the current chirp always completes. stop in IDLE SHALL have no effect.
REQ-027 From GAP, the FSM SHALL enter SWEEP with the accumulator reloaded from the latched start_inc. If stop arrives during GAP, it SHALL enter IDLE.
REQ-028 If start and stop are asserted in the same IDLE cycle, the sequence SHALL run exactly one chirp.
REQ-029 len==1 SHALL give a single sample with chirp_last=1.

Reset
REQ-030 reset SHALL asynchronously force state=IDLE, phase_valid=0, phase_data=0, chirp_last=0, busy=0, chirp_count=0, and clear the latched config and stop flag.
REQ-031 reset asserted mid-chirp SHALL abort immediately; no residual valid SHALL follow deassertion.

Verification
REQ-032 One-shot: start_inc=0x01000000, step=0x00010000, len=4, gap=0, continuous=0, ready=1 -> data 0x01000000, 0x01010000, 0x01020000, 0x01030000 (last on 4th), then IDLE, chirp_count=1.
REQ-033 Backpressure: same config, ready toggles 1,0,0,1,... -> identical data sequence, values held during ready=0, no skips or duplicates.
REQ-034 Continuous with gap: len=3, gap=2, continuous=1, stop after 3rd chirp starts -> three chirps, each followed by 2 invalid cycles except after the 3rd, which returns to IDLE; chirp_count=3.
REQ-035 Wrap/negative step: start_inc=0xFFFFFFFE, step=0x00000001, len=4 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001. With step=0xFFFFFFFF, start_inc=1, len=3 -> 1, 0, 0xFFFFFFFF.
REQ-036 Edge cases: start with len=0 -> busy stays 0. len=1, gap=0, continuous=1 -> last=1 on every valid cycle, back-to-back. Reset during sample 2 -> all outputs at reset values at once.
